id_ex_stage: RTL and testbench
==============================

ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 Parameter: DATA_W, 32, datapath width.
REQ-002 Parameter: REG_AW, 5, register address width.
REQ-003 Parameter: CTRL_W, 8, control bundle width.
REQ-004 Clocking and reset are fixed: one clock; reset is asynchronous and active-low. Ports are clk and rst_n.
REQ-005 clk  in  1  rising-edge clock.
REQ-006 rst_n  in  1  asynchronous active-low reset.
REQ-007 id_valid  in  1  decode slot holds a real instruction.
REQ-008 id_pc  in  DATA_W  PC+4 of the decode instruction.
REQ-009 id_rs, id_rt, id_rd  in  REG_AW each  source and destination fields.
REQ-010 id_rs_used, id_rt_used  in  1 each  source field is actually read.
REQ-011 id_imm  in  DATA_W  sign-extended immediate.
REQ-012 id_rd1, id_rd2  in  DATA_W  register-file read ports 1 and 2.
REQ-013 id_ctrl  in  CTRL_W  decoded control bundle (bit map held in the package).
REQ-014 wb_regwrite, wb_reg, wb_data  in  1/REG_AW/DATA_W  write-back port, in the same cycle as the register-file write.
REQ-015 flush  in  1  kill the decode instruction (branch or jump taken).
REQ-016 ex_stall  in  1  execute stage cannot accept a new instruction.
REQ-017 ex_valid, ex_pc, ex_rs, ex_rt, ex_rd, ex_imm, ex_rd1, ex_rd2, ex_ctrl  out  matching widths  registered execute-stage copies.
REQ-018 id_hold  out  1  combinational; holds the PC and the IF/ID register this cycle.
REQ-019 bubble_cnt  out  16  saturating count of inserted bubbles.

Function
REQ-020 Each rising clk edge takes exactly one action, in this priority order: flush > ex_stall > hazard > load.
REQ-021 Flush: ex_valid and ex_ctrl clear to 0; the other outputs are don't-care.
REQ-022 ex_stall with no flush: every ex_* output holds its value.
REQ-023 A load-use hazard exists when all of the following are true: ex_valid, ex_ctrl[MEMREAD], ex_rt != 0, and (id_rs_used and id_rs == ex_rt, or id_rt_used and id_rt == ex_rt).
REQ-024 Hazard with no flush or ex_stall: a bubble is inserted (ex_valid=0, ex_ctrl=0) and bubble_cnt increments, saturating at 16'hFFFF.
REQ-025 Load: all id_* inputs are captured into the ex_* outputs; ex_valid = id_valid.
REQ-026 id_hold = hazard or ex_stall, and is forced to 0 while flush=1.
REQ-027 Latency: decode to execute is 1 cycle; each hazard costs exactly 1 bubble cycle.
REQ-028 When id_valid=0, the hazard is suppressed and id_hold follows ex_stall only.
REQ-029 Register 0 never matches in any hazard or bypass comparison.

Reset
REQ-030 While rst_n=0, all outputs are 0: ex_valid=0, ex_ctrl=0, all ex_* data=0, bubble_cnt=0.
REQ-031 Reset asserted mid-hazard or mid-stall discards the pending instruction; the first edge after release performs a normal load.

Configuration
REQ-032 Macro ID_EX_WB_BYPASS_EN, defined: on load, if wb_regwrite and wb_reg != 0 and wb_reg == id_rs, ex_rd1 captures wb_data instead of id_rd1. ex_rd2 is handled the same way using id_rt.
REQ-033 Macro ID_EX_WB_BYPASS_EN, undefined: ex_rd1 and ex_rd2 capture id_rd1 and id_rd2 unmodified, and the wb_* ports are unused.

Structure
REQ-034 Package mips_pkg holds DATA_W, REG_AW, CTRL_W, and the control bit indices: REGWRITE=0, MEMREAD=1, MEMWRITE=2, MEMTOREG=3, ALUSRC=4, REGDST=5, BRANCH=6, JUMP=7.
REQ-035 Sub-module hazard_detect is combinational and produces the hazard signal; all state lives in id_ex_stage.

Verification
REQ-036 Load: id_valid=1, id_rd1=32'h1234, id_ctrl=8'h11 -> next edge ex_rd1=32'h1234, ex_ctrl=8'h11, ex_valid=1, id_hold=0.
REQ-037 Load-use: ex holds a load with ex_rt=5 and MEMREAD=1; id_rs=5, id_rs_used=1 -> id_hold=1, next edge ex_valid=0 and bubble_cnt=1; the following edge loads the instruction.
REQ-038 Flush during a hazard, with ex_stall=1 -> id_hold=0, next edge ex_valid=0, ex_ctrl=0, bubble_cnt unchanged.
REQ-039 ex_stall=1 for 3 cycles -> ex_* stable for 3 edges and id_hold=1 throughout.
REQ-040 Bypass build: wb_reg=7, wb_data=32'hCAFE, wb_regwrite=1, id_rs=7, id_rd1=32'h0 -> ex_rd1=32'hCAFE. With wb_reg=0 -> ex_rd1=32'h0. Non-bypass build -> ex_rd1=32'h0 in both cases.
REQ-041 rst_n pulsed low mid-stall -> all outputs 0 immediately; after release, a normal load on the first edge.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared widths and control-bundle bit positions for the MIPS pipeline slice.
package mips_pkg;

  localparam int DATA_W = 32;
  localparam int REG_AW = 5;
  localparam int CTRL_W = 8;

  localparam int REGWRITE = 0;
  localparam int MEMREAD  = 1;
  localparam int MEMWRITE = 2;
  localparam int MEMTOREG = 3;
  localparam int ALUSRC   = 4;
  localparam int REGDST   = 5;
  localparam int BRANCH   = 6;
  localparam int JUMP     = 7;

endpackage

// File: rtl/hazard_detect.sv
// Combinational load-use hazard check between the decode slot and the load sitting in execute.
module hazard_detect #(
  parameter int REG_AW = mips_pkg::REG_AW
) (
  input  logic              ex_valid_i,
  input  logic              ex_memread_i,
  input  logic [REG_AW-1:0] ex_rt_i,
  input  logic              id_valid_i,
  input  logic [REG_AW-1:0] id_rs_i,
  input  logic [REG_AW-1:0] id_rt_i,
  input  logic              id_rs_used_i,
  input  logic              id_rt_used_i,
  output logic              hazard_o
);

  logic rs_match;
  logic rt_match;

  assign rs_match = id_rs_used_i && (id_rs_i == ex_rt_i);
  assign rt_match = id_rt_used_i && (id_rt_i == ex_rt_i);

  // $zero is never a real dependency, and an empty decode slot cannot stall anything.
  assign hazard_o = ex_valid_i && ex_memread_i && (ex_rt_i != '0) && id_valid_i &&
                    (rs_match || rt_match);

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion, flush, stall and a bubble counter.
// Optional write-back bypass into the captured operands: define ID_EX_WB_BYPASS_EN.
module id_ex_stage #(
  parameter int DATA_W = mips_pkg::DATA_W,
  parameter int REG_AW = mips_pkg::REG_AW,
  parameter int CTRL_W = mips_pkg::CTRL_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [DATA_W-1:0] id_pc,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_rs_used,
  input  logic              id_rt_used,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [DATA_W-1:0] id_rd1,
  input  logic [DATA_W-1:0] id_rd2,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic              wb_regwrite,
  input  logic [REG_AW-1:0] wb_reg,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              flush,
  input  logic              ex_stall,
  output logic              ex_valid,
  output logic [DATA_W-1:0] ex_pc,
  output logic [REG_AW-1:0] ex_rs,
  output logic [REG_AW-1:0] ex_rt,
  output logic [REG_AW-1:0] ex_rd,
  output logic [DATA_W-1:0] ex_imm,
  output logic [DATA_W-1:0] ex_rd1,
  output logic [DATA_W-1:0] ex_rd2,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic              id_hold,
  output logic [15:0]       bubble_cnt
);
  import mips_pkg::*;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic              valid_q, valid_d;
  logic [DATA_W-1:0] pc_q, pc_d, imm_q, imm_d, rd1_q, rd1_d, rd2_q, rd2_d;
  logic [REG_AW-1:0] rs_q, rs_d, rt_q, rt_d, rd_q, rd_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic [15:0]       cnt_q, cnt_d;
  logic              hazard;
  logic [DATA_W-1:0] opnd1, opnd2;

  hazard_detect #(.REG_AW(REG_AW)) u_hazard (
    .ex_valid_i   (valid_q),
    .ex_memread_i (ctrl_q[MEMREAD]),
    .ex_rt_i      (rt_q),
    .id_valid_i   (id_valid),
    .id_rs_i      (id_rs),
    .id_rt_i      (id_rt),
    .id_rs_used_i (id_rs_used),
    .id_rt_used_i (id_rt_used),
    .hazard_o     (hazard)
  );

`ifdef ID_EX_WB_BYPASS_EN
  // The register file is written this same cycle, so its read ports still show the old value.
  assign opnd1 = (wb_regwrite && (wb_reg != '0) && (wb_reg == id_rs)) ? wb_data : id_rd1;
  assign opnd2 = (wb_regwrite && (wb_reg != '0) && (wb_reg == id_rt)) ? wb_data : id_rd2;
`else
  logic unused_wb;
  assign unused_wb = ^{wb_regwrite, wb_reg, wb_data};
  assign opnd1     = id_rd1;
  assign opnd2     = id_rd2;
`endif

  assign id_hold = !flush && (hazard || ex_stall);

  always_comb begin
    valid_d = valid_q;
    pc_d    = pc_q;
    rs_d    = rs_q;
    rt_d    = rt_q;
    rd_d    = rd_q;
    imm_d   = imm_q;
    rd1_d   = rd1_q;
    rd2_d   = rd2_q;
    ctrl_d  = ctrl_q;
    cnt_d   = cnt_q;
    if (flush) begin
      valid_d = 1'b0;
      ctrl_d  = '0;
    end else if (!ex_stall) begin
      if (hazard) begin
        valid_d = 1'b0;
        ctrl_d  = '0;
        cnt_d   = sat_inc16(cnt_q);
      end else begin
        valid_d = id_valid;
        pc_d    = id_pc;
        rs_d    = id_rs;
        rt_d    = id_rt;
        rd_d    = id_rd;
        imm_d   = id_imm;
        rd1_d   = opnd1;
        rd2_d   = opnd2;
        ctrl_d  = id_ctrl;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      pc_q    <= '0;
      rs_q    <= '0;
      rt_q    <= '0;
      rd_q    <= '0;
      imm_q   <= '0;
      rd1_q   <= '0;
      rd2_q   <= '0;
      ctrl_q  <= '0;
      cnt_q   <= '0;
    end else begin
      valid_q <= valid_d;
      pc_q    <= pc_d;
      rs_q    <= rs_d;
      rt_q    <= rt_d;
      rd_q    <= rd_d;
      imm_q   <= imm_d;
      rd1_q   <= rd1_d;
      rd2_q   <= rd2_d;
      ctrl_q  <= ctrl_d;
      cnt_q   <= cnt_d;
    end
  end

  assign ex_valid   = valid_q;
  assign ex_pc      = pc_q;
  assign ex_rs      = rs_q;
  assign ex_rt      = rt_q;
  assign ex_rd      = rd_q;
  assign ex_imm     = imm_q;
  assign ex_rd1     = rd1_q;
  assign ex_rd2     = rd2_q;
  assign ex_ctrl    = ctrl_q;
  assign bubble_cnt = cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed vector table, hand sequences for flush/stall/reset/bypass, random vs model.
module tb_id_ex_stage;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int CW = 8;

  typedef struct packed {
    logic          v;
    logic [DW-1:0] pc;
    logic [AW-1:0] rs, rt, rd;
    logic          rsu, rtu;
    logic [DW-1:0] imm, rd1, rd2;
    logic [CW-1:0] ctrl;
    logic          wbw;
    logic [AW-1:0] wbr;
    logic [DW-1:0] wbd;
    logic          fl, st;
  } in_t;

  typedef struct {
    in_t           i;
    logic          e_hold;
    logic          e_valid;
    logic [CW-1:0] e_ctrl;
    logic          chk_rd1;
    logic [DW-1:0] e_rd1;
    logic [15:0]   e_cnt;
  } vec_t;

  logic          clk, rst_n;
  logic          id_valid, id_rs_used, id_rt_used, wb_regwrite, flush, ex_stall;
  logic [DW-1:0] id_pc, id_imm, id_rd1, id_rd2, wb_data;
  logic [AW-1:0] id_rs, id_rt, id_rd, wb_reg;
  logic [CW-1:0] id_ctrl;
  logic          ex_valid, id_hold;
  logic [DW-1:0] ex_pc, ex_imm, ex_rd1, ex_rd2;
  logic [AW-1:0] ex_rs, ex_rt, ex_rd;
  logic [CW-1:0] ex_ctrl;
  logic [15:0]   bubble_cnt;

  int nvec = 0;
  int nerr = 0;

  id_ex_stage dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_pc(id_pc), .id_rs(id_rs),
    .id_rt(id_rt), .id_rd(id_rd), .id_rs_used(id_rs_used), .id_rt_used(id_rt_used),
    .id_imm(id_imm), .id_rd1(id_rd1), .id_rd2(id_rd2), .id_ctrl(id_ctrl),
    .wb_regwrite(wb_regwrite), .wb_reg(wb_reg), .wb_data(wb_data), .flush(flush),
    .ex_stall(ex_stall), .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rs(ex_rs), .ex_rt(ex_rt),
    .ex_rd(ex_rd), .ex_imm(ex_imm), .ex_rd1(ex_rd1), .ex_rd2(ex_rd2), .ex_ctrl(ex_ctrl),
    .id_hold(id_hold), .bubble_cnt(bubble_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  function automatic in_t mk(input logic v, input logic [AW-1:0] rs, input logic [AW-1:0] rt,
                             input logic rsu, input logic rtu, input logic [DW-1:0] rd1,
                             input logic [CW-1:0] ctrl, input logic fl, input logic st);
    in_t x;
    x      = '0;
    x.v    = v;
    x.rs   = rs;
    x.rt   = rt;
    x.rd   = rs + 5'd1;
    x.rsu  = rsu;
    x.rtu  = rtu;
    x.rd1  = rd1;
    x.rd2  = ~rd1;
    x.pc   = rd1 + 32'd4;
    x.imm  = {16'h0, rd1[15:0]};
    x.ctrl = ctrl;
    x.fl   = fl;
    x.st   = st;
    return x;
  endfunction

  task automatic apply(input in_t x);
    id_valid    = x.v;
    id_pc       = x.pc;
    id_rs       = x.rs;
    id_rt       = x.rt;
    id_rd       = x.rd;
    id_rs_used  = x.rsu;
    id_rt_used  = x.rtu;
    id_imm      = x.imm;
    id_rd1      = x.rd1;
    id_rd2      = x.rd2;
    id_ctrl     = x.ctrl;
    wb_regwrite = x.wbw;
    wb_reg      = x.wbr;
    wb_data     = x.wbd;
    flush       = x.fl;
    ex_stall    = x.st;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_valid"}, ex_valid, 0);
    chk({tag, "_ctrl"}, ex_ctrl, 0);
    chk({tag, "_pc"}, ex_pc, 0);
    chk({tag, "_rd1"}, ex_rd1, 0);
    chk({tag, "_rd2"}, ex_rd2, 0);
    chk({tag, "_regs"}, {ex_rs, ex_rt, ex_rd}, 0);
    chk({tag, "_imm"}, ex_imm, 0);
    chk({tag, "_cnt"}, bubble_cnt, 0);
  endtask

  vec_t tbl[8];

  // Reference model state for the random phase
  logic          m_v, m_known;
  logic [CW-1:0] m_ctrl;
  logic [AW-1:0] m_rs, m_rt, m_rd;
  logic [DW-1:0] m_pc, m_imm, m_rd1, m_rd2;
  logic [15:0]   m_cnt;

  initial begin
    in_t x;
    logic m_hz, e_hold;
    logic [DW-1:0] exp_rd1;

    // Load, then a load followed by a dependent use, register-0 cases, and an empty decode slot.
    tbl[0] = '{mk(1, 1, 3, 1, 0, 32'h1234, 8'h11, 0, 0), 0, 1, 8'h11, 1, 32'h1234, 0};
    tbl[1] = '{mk(1, 2, 5, 1, 0, 32'hAAAA, 8'h0B, 0, 0), 0, 1, 8'h0B, 1, 32'hAAAA, 0};
    tbl[2] = '{mk(1, 5, 6, 1, 0, 32'h5555, 8'h01, 0, 0), 1, 0, 8'h00, 0, 32'h0, 1};
    tbl[3] = '{mk(1, 5, 6, 1, 0, 32'h5555, 8'h01, 0, 0), 0, 1, 8'h01, 1, 32'h5555, 1};
    tbl[4] = '{mk(1, 9, 0, 1, 0, 32'h0077, 8'h0B, 0, 0), 0, 1, 8'h0B, 1, 32'h0077, 1};
    tbl[5] = '{mk(1, 0, 0, 1, 1, 32'h0088, 8'h01, 0, 0), 0, 1, 8'h01, 1, 32'h0088, 1};
    tbl[6] = '{mk(1, 1, 4, 1, 0, 32'h0099, 8'h02, 0, 0), 0, 1, 8'h02, 1, 32'h0099, 1};
    tbl[7] = '{mk(0, 4, 4, 1, 1, 32'h00AB, 8'h03, 0, 0), 0, 0, 8'h03, 1, 32'h00AB, 1};

    rst_n = 1'b0;
    apply(mk(1, 3, 4, 1, 1, 32'hFFFF_0000, 8'hFF, 0, 0));
    tick();
    tick();
    chk_zero("reset");
    rst_n = 1'b1;

    for (int k = 0; k < 8; k++) begin
      apply(tbl[k].i);
      #3;
      chk($sformatf("tbl%0d_hold", k), id_hold, tbl[k].e_hold);
      tick();
      chk($sformatf("tbl%0d_valid", k), ex_valid, tbl[k].e_valid);
      chk($sformatf("tbl%0d_ctrl", k), ex_ctrl, tbl[k].e_ctrl);
      chk($sformatf("tbl%0d_cnt", k), bubble_cnt, tbl[k].e_cnt);
      if (tbl[k].chk_rd1) chk($sformatf("tbl%0d_rd1", k), ex_rd1, tbl[k].e_rd1);
    end

    // Flush wins over a pending hazard and a stall; no bubble is counted.
    apply(mk(1, 2, 5, 1, 0, 32'h0111, 8'h0B, 0, 0));
    tick();
    apply(mk(1, 5, 6, 1, 0, 32'h0222, 8'h01, 1, 1));
    #3;
    chk("flush_hold", id_hold, 0);
    tick();
    chk("flush_valid", ex_valid, 0);
    chk("flush_ctrl", ex_ctrl, 0);
    chk("flush_cnt", bubble_cnt, 1);

    // Three stall cycles keep execute frozen while decode is held.
    apply(mk(1, 3, 8, 1, 1, 32'h3333, 8'h21, 0, 0));
    tick();
    for (int k = 0; k < 3; k++) begin
      apply(mk(1, 10, 11, 1, 1, 32'hDEAD, 8'hFF, 0, 1));
      #3;
      chk($sformatf("stall%0d_hold", k), id_hold, 1);
      tick();
      chk($sformatf("stall%0d_valid", k), ex_valid, 1);
      chk($sformatf("stall%0d_ctrl", k), ex_ctrl, 8'h21);
      chk($sformatf("stall%0d_rd1", k), ex_rd1, 32'h3333);
      chk($sformatf("stall%0d_pc", k), ex_pc, 32'h3337);
    end

    // Reset pulse mid-stall clears everything at once, then the next edge loads normally.
    rst_n = 1'b0;
    #1;
    chk_zero("rstmid");
    #1;
    rst_n = 1'b1;
    apply(mk(1, 12, 13, 1, 1, 32'h4444, 8'h11, 0, 0));
    tick();
    chk("rstrel_valid", ex_valid, 1);
    chk("rstrel_ctrl", ex_ctrl, 8'h11);
    chk("rstrel_rd1", ex_rd1, 32'h4444);
    chk("rstrel_cnt", bubble_cnt, 0);

    // Write-back bypass into rd1, then the same with $zero as the write target.
    x = mk(1, 7, 9, 1, 0, 32'h0, 8'h01, 0, 0);
    x.wbw = 1;
    x.wbr = 7;
    x.wbd = 32'hCAFE;
    apply(x);
    tick();
`ifdef ID_EX_WB_BYPASS_EN
    chk("bypass_rd1", ex_rd1, 32'hCAFE);
`else
    chk("bypass_rd1", ex_rd1, 32'h0);
`endif
    x.wbr = 0;
    x.rs  = 0;
    apply(x);
    tick();
    chk("bypass_r0_rd1", ex_rd1, 32'h0);

    // Random phase against the model, from a fresh reset.
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    m_v = 0; m_known = 1; m_ctrl = 0; m_rs = 0; m_rt = 0; m_rd = 0;
    m_pc = 0; m_imm = 0; m_rd1 = 0; m_rd2 = 0; m_cnt = 0;
    for (int n = 0; n < 400; n++) begin
      x      = '0;
      x.v    = ($urandom_range(0, 7) != 0);
      x.pc   = $urandom;
      x.rs   = AW'($urandom_range(0, 7));
      x.rt   = AW'($urandom_range(0, 7));
      x.rd   = AW'($urandom);
      x.rsu  = 1'($urandom);
      x.rtu  = 1'($urandom);
      x.imm  = $urandom;
      x.rd1  = $urandom;
      x.rd2  = $urandom;
      x.ctrl = ($urandom_range(0, 2) == 0) ? 8'h0B : CW'($urandom);
      x.wbw  = 1'($urandom);
      x.wbr  = AW'($urandom_range(0, 7));
      x.wbd  = $urandom;
      x.fl   = ($urandom_range(0, 7) == 0);
      x.st   = ($urandom_range(0, 4) == 0);
      apply(x);

      m_hz = m_v && m_ctrl[1] && (m_rt != 0) && x.v &&
             ((x.rsu && x.rs == m_rt) || (x.rtu && x.rt == m_rt));
      e_hold = !x.fl && (m_hz || x.st);
      #3;
      chk("rnd_hold", id_hold, e_hold);

      if (x.fl) begin
        m_v = 0; m_ctrl = 0; m_known = 0;
      end else if (x.st) begin
        m_v = m_v;
      end else if (m_hz) begin
        m_v = 0; m_ctrl = 0; m_known = 0;
        if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 1;
      end else begin
        m_v = x.v; m_ctrl = x.ctrl; m_known = 1;
        m_pc = x.pc; m_rs = x.rs; m_rt = x.rt; m_rd = x.rd; m_imm = x.imm;
        m_rd1 = x.rd1;
        m_rd2 = x.rd2;
`ifdef ID_EX_WB_BYPASS_EN
        if (x.wbw && x.wbr != 0 && x.wbr == x.rs) m_rd1 = x.wbd;
        if (x.wbw && x.wbr != 0 && x.wbr == x.rt) m_rd2 = x.wbd;
`endif
      end
      tick();
      chk("rnd_valid", ex_valid, m_v);
      chk("rnd_ctrl", ex_ctrl, m_ctrl);
      chk("rnd_cnt", bubble_cnt, m_cnt);
      if (m_known) begin
        chk("rnd_pc", ex_pc, m_pc);
        chk("rnd_regs", {ex_rs, ex_rt, ex_rd}, {m_rs, m_rt, m_rd});
        chk("rnd_imm", ex_imm, m_imm);
        chk("rnd_rd1", ex_rd1, m_rd1);
        chk("rnd_rd2", ex_rd2, m_rd2);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
